// File: rtl/adc_capture_pkg.sv
// adc_capture_pkg: shared types and constants for the paced ADC capture stage.
package adc_capture_pkg;

    // Capture sequencer states
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_TICK = 2'd1,
        WRITE     = 2'd2,
        DONE      = 2'd3
    } capture_state_e;

    // Width of one mcp3002 conversion
    localparam int ADC_DATA_W     = 10;

    // Address width of the Gowin_SP_adc sample RAM (8192 entries)
    localparam int ADC_RAM_ADDR_W = 13;

    // Number of system clocks between two samples
    function automatic int calc_div(input int clk_hz, input int sample_hz);
        return clk_hz / sample_hz;
    endfunction

endpackage

// File: rtl/adc_capture_if.sv
// adc_capture_if: ADC handshake plus BSRAM write port seen by the capture stage.
// The master side is the capture block, the slave side is the ADC/RAM pair.
interface adc_capture_if
    import adc_capture_pkg::*;
#(
    parameter int ADDR_W = ADC_RAM_ADDR_W,
    parameter int DATA_W = ADC_DATA_W
);
    logic              adc_enable;
    logic [DATA_W-1:0] adc_data;
    logic              adc_available;
    logic              adc_clear_available;

    logic              sp_adc_oce;
    logic              sp_adc_ce;
    logic              sp_adc_wre;
    logic [ADDR_W-1:0] sp_adc_ad;
    logic [DATA_W-1:0] sp_adc_din;

    modport master (
        output adc_enable,
        input  adc_data,
        input  adc_available,
        output adc_clear_available,
        output sp_adc_oce,
        output sp_adc_ce,
        output sp_adc_wre,
        output sp_adc_ad,
        output sp_adc_din
    );

    modport slave (
        input  adc_enable,
        output adc_data,
        output adc_available,
        input  adc_clear_available,
        input  sp_adc_oce,
        input  sp_adc_ce,
        input  sp_adc_wre,
        input  sp_adc_ad,
        input  sp_adc_din
    );

endinterface

// File: rtl/adc_capture_sample_tick_gen.sv
// sample_tick_gen: free-running modulo-DIV counter producing a one-cycle tick on its
// last count. restart forces the count to zero; enable freezes it when low.
module sample_tick_gen #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    input  logic enable,
    output logic tick
);
    localparam int              CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: restart wins, otherwise wrap at the last count while enabled
    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = enable && (cnt_q == LAST);

endmodule

// File: rtl/adc_capture.sv
// adc_capture: on start, writes one ADC sample every DIV clocks into the sample
// BSRAM until the programmed length is reached, then holds finish until clear.
// Missing conversions are replaced by the previous sample and flagged in underrun.
// Build macro ADC_CAPTURE_SIGNED_EN: store samples as two's complement (MSB inverted).
module adc_capture
    import adc_capture_pkg::*;
#(
    parameter int CLK_FREQ          = 48_000_000,
    parameter int ADC_SAMPLING_FREQ = 48_000,
    parameter int ADDR_W            = ADC_RAM_ADDR_W,
    parameter int DATA_W            = ADC_DATA_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [ADDR_W:0] length,
    input  logic            clear,
    output logic            finish,
    output logic            busy,
    output logic            underrun,
    output logic [ADDR_W:0] count,
    adc_capture_if.master   bus
);
    // DIV must be at least 4 so the WRITE cycle never lands on a tick
    localparam int              DIV   = calc_div(CLK_FREQ, ADC_SAMPLING_FREQ);
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    capture_state_e    state_q, state_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              underrun_q, underrun_d;
    logic              finish_q, finish_d;
    logic              busy_q, busy_d;
    logic              clr_avail_q, clr_avail_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] ad_q, ad_d;
    logic [DATA_W-1:0] din_q, din_d;

    logic              tick;
    logic              tick_restart;
    logic              tick_enable;
    logic [ADDR_W:0]   count_inc;

    function automatic logic [DATA_W-1:0] to_ram(input logic [DATA_W-1:0] raw);
`ifdef ADC_CAPTURE_SIGNED_EN
        return {~raw[DATA_W-1], raw[DATA_W-2:0]};
`else
        return raw;
`endif
    endfunction

    assign tick_restart = (state_q == IDLE) && start;
    assign tick_enable  = (state_q == WAIT_TICK) || (state_q == WRITE);
    assign count_inc    = count_q + 1'b1;

    sample_tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (tick_restart),
        .enable  (tick_enable),
        .tick    (tick)
    );

    // Sequencer next-state and next-output logic; outputs are registered from these
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        count_d     = count_q;
        underrun_d  = underrun_q;
        clr_avail_d = 1'b0;
        wr_d        = 1'b0;
        ad_d        = ad_q;
        din_d       = din_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    underrun_d = 1'b0;
                    if (length == '0) begin
                        state_d = DONE;
                    end else begin
                        len_d   = (length > DEPTH) ? DEPTH : length;
                        count_d = '0;
                        state_d = WAIT_TICK;
                    end
                end
            end
            WAIT_TICK: begin
                if (tick) begin
                    state_d = WRITE;
                    wr_d    = 1'b1;
                    ad_d    = count_q[ADDR_W-1:0];
                    if (bus.adc_available) begin
                        din_d       = to_ram(bus.adc_data);
                        clr_avail_d = 1'b1;
                    end else begin
                        underrun_d  = 1'b1;
                    end
                end
            end
            WRITE: begin
                count_d = count_inc;
                state_d = (count_inc == len_q) ? DONE : WAIT_TICK;
            end
            DONE: begin
                if (clear) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d   = (state_d == WAIT_TICK) || (state_d == WRITE);
        finish_d = (state_d == DONE);
    end

    // Sequencer state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            len_q       <= '0;
            count_q     <= '0;
            underrun_q  <= 1'b0;
            finish_q    <= 1'b0;
            busy_q      <= 1'b0;
            clr_avail_q <= 1'b0;
            wr_q        <= 1'b0;
            ad_q        <= '0;
            din_q       <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            count_q     <= count_d;
            underrun_q  <= underrun_d;
            finish_q    <= finish_d;
            busy_q      <= busy_d;
            clr_avail_q <= clr_avail_d;
            wr_q        <= wr_d;
            ad_q        <= ad_d;
            din_q       <= din_d;
        end
    end

    assign finish                  = finish_q;
    assign busy                    = busy_q;
    assign underrun                = underrun_q;
    assign count                   = count_q;
    assign bus.adc_enable          = busy_q;
    assign bus.adc_clear_available = clr_avail_q;
    assign bus.sp_adc_oce          = 1'b1;
    assign bus.sp_adc_ce           = wr_q;
    assign bus.sp_adc_wre          = wr_q;
    assign bus.sp_adc_ad           = ad_q;
    assign bus.sp_adc_din          = din_q;

endmodule

// File: doc/adc_capture.md
# adc_capture

Paced capture stage between the `mcp3002` ADC interface and the `Gowin_SP_adc` sample BSRAM. On a `start` pulse it takes one ADC sample every `CLK_FREQ/ADC_SAMPLING_FREQ` clocks. It writes a programmed number of samples sequentially into the BSRAM, then holds `finish` so `demodulation` can hand the buffer to `fft1024`. Missed conversions are flagged and never stall capture.

## Interface
Parameters:
- `CLK_FREQ`, 48_000_000: system clock in Hz.
- `ADC_SAMPLING_FREQ`, 48_000: sample rate in Hz. `DIV = CLK_FREQ/ADC_SAMPLING_FREQ`, which must be ≥ 4.
- `ADDR_W`, 13: BSRAM address width. Depth is `2**ADDR_W`.
- `DATA_W`, 10: ADC sample width.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low (`clk`, `rst_n`).
- `clk` in 1: system clock (`clk_pll`).
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: one-cycle pulse that begins a capture.
- `length` in ADDR_W+1: number of samples; latched on an accepted `start`.
- `clear` in 1: acknowledges `finish` and returns the block to IDLE.
- `finish` out 1: level; capture complete.
- `busy` out 1: high in WAIT_TICK or WRITE.
- `underrun` out 1: sticky; a tick found no fresh sample. Cleared on an accepted `start`.
- `count` out ADDR_W+1: samples written so far.
- `adc_enable` out 1: high while busy.
- `adc_data` in DATA_W: latest ADC conversion.
- `adc_available` in 1: a fresh conversion is present.
- `adc_clear_available` out 1: one-cycle acknowledge of `adc_available`.
- `sp_adc_oce` out 1: BSRAM output-register enable; tied to 1.
- `sp_adc_ce` out 1: BSRAM clock enable; pulsed on write.
- `sp_adc_wre` out 1: BSRAM write enable; pulsed on write.
- `sp_adc_ad` out ADDR_W: BSRAM address.
- `sp_adc_din` out DATA_W: BSRAM write data.

## Operation
State machine:
- **IDLE**: waits for `start`.
  - `start` with `length == 0` goes to DONE.
  - Otherwise it latches `len = min(length, 2**ADDR_W)`, zeroes `count`, the tick counter and `underrun`, and goes to WAIT_TICK.
- **WAIT_TICK**: the tick counter runs 0..DIV-1. When it reaches DIV-1, the state goes to WRITE and the counter wraps to 0.
- **WRITE** (exactly one cycle):
  - Asserts `sp_adc_ce = sp_adc_wre = 1`, `sp_adc_ad = count[ADDR_W-1:0]`, `sp_adc_din = sample`.
  - If `adc_available` was 1 at the tick, `sample = adc_data` sampled at the tick, and `adc_clear_available` pulses in this WRITE cycle.
  - Otherwise `sample` = the previous written sample (0 if none), `underrun` sets, and there is no acknowledge.
  - `count` increments. If `count+1 == len`, go to DONE; else go to WAIT_TICK, with the tick counter continuing so the period stays exactly DIV.
- **DONE**: `finish = 1` and `adc_enable = 0`. `clear` goes to IDLE.

Boundary and precedence rules:
- `start` outside IDLE is ignored.
- `clear` outside DONE is ignored.
- `start` and `clear` in the same cycle in DONE: `clear` wins and `start` is dropped.
- `length > 2**ADDR_W`: clamped. The address never wraps; the last write goes to `2**ADDR_W - 1`.
- `adc_available` arriving mid-period: held by `mcp3002` until acknowledged. Only the value present at the tick is used.
- `rst_n` low mid-capture: all state and outputs return to reset values immediately. Partial RAM content is undefined to consumers.

## Timing
- Reset values: `finish = busy = underrun = adc_enable = adc_clear_available = sp_adc_ce = sp_adc_wre = 0`, `sp_adc_oce = 1`, `count = sp_adc_ad = sp_adc_din = 0`, state IDLE.
- `start` accepted at edge 0: `busy` and `adc_enable` rise at edge 1. The first tick is at edge DIV and the first write at edge DIV+1.
- Writes are exactly DIV cycles apart.
- `finish` rises on the edge after the last write (one cycle after the WRITE state).
- `finish` falls, and IDLE is re-entered, the cycle after `clear`.
- `length == 0`: `finish` rises one cycle after `start`.

## Configuration
- `ADC_CAPTURE_SIGNED_EN` defined: `sp_adc_din` = `adc_data` with its MSB inverted, i.e. two's-complement offset by −2^(DATA_W−1), so 512 → 0 and 0 → −512. The held sample on underrun is the converted value.
- `ADC_CAPTURE_SIGNED_EN` undefined: raw unsigned `adc_data` is written.

## Structure
- Shared package `adc_capture_pkg`:
  - state encoding (IDLE, WAIT_TICK, WRITE, DONE);
  - `ADC_DATA_W = 10`;
  - `ADC_RAM_ADDR_W = 13`;
  - the `DIV` computation function.
- One sub-module, `sample_tick_gen`: a parameterised DIV divider with synchronous `restart` and a one-cycle `tick` output.

## Test plan
Use `CLK_FREQ = 48_000` and `ADC_SAMPLING_FREQ = 4_800` (DIV = 10), with a bench ADC model that raises `adc_available` 3 cycles after each acknowledge.
- `start`, `length = 4`, `adc_data = 100, 101, 102, 103` → writes at cycles 11/21/31/41 to addresses 0..3; `finish` at 42; `underrun = 0`; `count = 4`.
- ADC model withholds the second sample → address 1 gets 100 again; `underrun = 1`; `clear` then `start` resets `underrun` to 0.
- `length = 0` → `finish` one cycle after `start`; no `sp_adc_wre` pulse.
- `length = 9000` → exactly 8192 writes, last to address 8191; `count = 8192`.
- `rst_n` low after 2 writes → all outputs at reset values in the same cycle; `start` and `clear` pulses during capture are ignored.
- `ADC_CAPTURE_SIGNED_EN` defined with `adc_data = 512`, then `0` → `sp_adc_din = 0`, then `10'h200`.
